// File: rtl/tx_send_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sys_ctrl_pkg
// Brief    : Shared state encoding and send-control codes for the transmit
//            sequencer and the transmit-data register stage.
// Revision : 1.0 - initial release
// ============================================================================
package sys_ctrl_pkg;

  // Send-control code driven into the transmit-data register stage
  typedef logic [1:0] send_code_t;

  localparam send_code_t SEND_NONE   = 2'b00;
  localparam send_code_t SEND_ALU_W0 = 2'b10;
  localparam send_code_t SEND_ALU_W1 = 2'b01;
  localparam send_code_t SEND_REG    = 2'b11;

  // Scheduler states
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ISSUE     = 3'd1;
  localparam logic [2:0] ST_WAIT_ACK  = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_NEXT      = 3'd4;

  // Meaning of the last_grant flag
  localparam logic GRANT_ALU = 1'b0;
  localparam logic GRANT_REG = 1'b1;

endpackage
`default_nettype wire

// File: rtl/tx_send_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : tx_send_scheduler_if
// Brief    : Request/handshake bundle between the system controller, the
//            transmit sequencer and the UART TX pacing signal.
// Revision : 1.0 - initial release
// ============================================================================
interface tx_send_scheduler_if;

  logic                    alu_res_vld;
  logic                    alu_two_word;
  logic                    reg_rd_vld;
  logic                    tx_busy;
  sys_ctrl_pkg::send_code_t send_ctrl_sig;
  logic                    alu_word_sel;
  logic                    sched_busy;
  logic                    tx_timeout_err;
  logic                    req_ovf_err;

  // Requester / UART side
  modport master (
    output alu_res_vld, alu_two_word, reg_rd_vld, tx_busy,
    input  send_ctrl_sig, alu_word_sel, sched_busy, tx_timeout_err, req_ovf_err
  );

  // Scheduler side
  modport slave (
    input  alu_res_vld, alu_two_word, reg_rd_vld, tx_busy,
    output send_ctrl_sig, alu_word_sel, sched_busy, tx_timeout_err, req_ovf_err
  );

endinterface
`default_nettype wire

// File: rtl/tx_send_scheduler_tx_ack_timer.sv
`default_nettype none
// ============================================================================
// Module   : tx_ack_timer
// Brief    : Clear/enable counter that flags when the acknowledge window
//            has reached its last cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tx_ack_timer #(
  parameter int ACK_TIMEOUT = 16,
  parameter int TO_WIDTH    = 5
) (
  input  wire logic CLK,
  input  wire logic RST,
  input  wire logic clr,
  input  wire logic en,
  output logic      expire
);

  localparam logic [TO_WIDTH-1:0] C_LAST = TO_WIDTH'(ACK_TIMEOUT - 1);

  logic [TO_WIDTH-1:0] cnt_q;
  logic [TO_WIDTH-1:0] cnt_d;

  // Clear has priority; otherwise count while enabled
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/tx_send_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tx_send_scheduler
// Brief    : Round-robin arbiter and word sequencer for the transmit path.
//            Issues one send-control code per word and paces the next word
//            on the UART TX busy handshake, with an acknowledge timeout.
// Revision : 1.0 - initial release
// ============================================================================
module tx_send_scheduler
  import sys_ctrl_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16,
  parameter int TO_WIDTH    = 5
) (
  input  wire logic           CLK,
  input  wire logic           RST,
  tx_send_scheduler_if.slave  bus
);

  logic [2:0] state_q,      state_d;
  send_code_t send_ctrl_q,  send_ctrl_d;
  logic       word_sel_q,   word_sel_d;
  logic       sched_busy_q, sched_busy_d;
  logic       tout_err_q,   tout_err_d;
  logic       ovf_err_q,    ovf_err_d;
  logic       alu_pend_q,   alu_pend_d;
  logic       alu_two_q,    alu_two_d;
  logic       reg_pend_q,   reg_pend_d;
  logic       last_grant_q, last_grant_d;

  logic       grant;
  logic       clr_alu;
  logic       clr_reg;
  logic       tmr_expire;

  // The acknowledge window restarts on every issued word
  tx_ack_timer #(
    .ACK_TIMEOUT (ACK_TIMEOUT),
    .TO_WIDTH    (TO_WIDTH)
  ) u_ack_timer (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (state_q == ST_ISSUE),
    .en     ((state_q == ST_WAIT_ACK) && !bus.tx_busy),
    .expire (tmr_expire)
  );

  // Arbitration and word sequencing
  always_comb begin
    state_d      = state_q;
    send_ctrl_d  = SEND_NONE;
    word_sel_d   = word_sel_q;
    last_grant_d = last_grant_q;
    tout_err_d   = 1'b0;
    clr_alu      = 1'b0;
    clr_reg      = 1'b0;
    grant        = GRANT_ALU;
    case (state_q)
      ST_IDLE: begin
        if (!bus.tx_busy && (alu_pend_q || reg_pend_q)) begin
          // Both pending: favour whichever type did not win last time
          grant        = (alu_pend_q && reg_pend_q) ? ~last_grant_q : reg_pend_q;
          last_grant_d = grant;
          state_d      = ST_ISSUE;
          if (grant == GRANT_REG) begin
            send_ctrl_d = SEND_REG;
          end else begin
            send_ctrl_d = SEND_ALU_W0;
            word_sel_d  = 1'b0;
          end
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (bus.tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (tmr_expire) begin
          // No acknowledge seen: report it and carry on as if sent
          tout_err_d = 1'b1;
          state_d    = ST_NEXT;
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.tx_busy) begin
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if ((last_grant_q == GRANT_ALU) && alu_two_q && !word_sel_q) begin
          state_d     = ST_ISSUE;
          send_ctrl_d = SEND_ALU_W1;
          word_sel_d  = 1'b1;
        end else begin
          clr_alu    = (last_grant_q == GRANT_ALU);
          clr_reg    = (last_grant_q == GRANT_REG);
          word_sel_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Request capture; a new pulse beats a same-cycle completion clear
  always_comb begin
    alu_pend_d = alu_pend_q;
    alu_two_d  = alu_two_q;
    reg_pend_d = reg_pend_q;
    ovf_err_d  = ovf_err_q;
    if (clr_alu) alu_pend_d = 1'b0;
    if (clr_reg) reg_pend_d = 1'b0;
    if (bus.alu_res_vld) begin
      if (alu_pend_q && !clr_alu) begin
        ovf_err_d = 1'b1;
      end else begin
        alu_pend_d = 1'b1;
        alu_two_d  = bus.alu_two_word;
      end
    end
    if (bus.reg_rd_vld) begin
      if (reg_pend_q && !clr_reg) begin
        ovf_err_d = 1'b1;
      end else begin
        reg_pend_d = 1'b1;
      end
    end
    sched_busy_d = (state_d != ST_IDLE) || alu_pend_d || reg_pend_d;
  end

  // State, request flags and registered outputs
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q      <= ST_IDLE;
      send_ctrl_q  <= SEND_NONE;
      word_sel_q   <= 1'b0;
      sched_busy_q <= 1'b0;
      tout_err_q   <= 1'b0;
      ovf_err_q    <= 1'b0;
      alu_pend_q   <= 1'b0;
      alu_two_q    <= 1'b0;
      reg_pend_q   <= 1'b0;
      last_grant_q <= GRANT_ALU;
    end else begin
      state_q      <= state_d;
      send_ctrl_q  <= send_ctrl_d;
      word_sel_q   <= word_sel_d;
      sched_busy_q <= sched_busy_d;
      tout_err_q   <= tout_err_d;
      ovf_err_q    <= ovf_err_d;
      alu_pend_q   <= alu_pend_d;
      alu_two_q    <= alu_two_d;
      reg_pend_q   <= reg_pend_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.send_ctrl_sig  = send_ctrl_q;
  assign bus.alu_word_sel   = word_sel_q;
  assign bus.sched_busy     = sched_busy_q;
  assign bus.tx_timeout_err = tout_err_q;
  assign bus.req_ovf_err    = ovf_err_q;

endmodule
`default_nettype wire

// File: tb/tb_tx_send_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_send_scheduler
// Brief    : Directed and randomized bench for tx_send_scheduler with a
//            transfer-level reference model and a simple UART busy emulator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tx_send_scheduler;

  localparam int ACK_TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tx_send_scheduler_if ifc();

  tx_send_scheduler #(
    .ACK_TIMEOUT (ACK_TO),
    .TO_WIDTH    (5)
  ) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (ifc.slave)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: pending requests plus the word list of the transfer
  bit         m_apend, m_atwo, m_rpend, m_last, m_ovf;
  bit         m_active, m_acked, m_fin;
  int         m_age;
  logic [1:0] m_words[$];
  logic [1:0] m_code;
  bit         m_sel, m_sbusy, m_terr;

  // UART emulator: busy rises cfg_dly cycles after a code, lasts cfg_len
  int cfg_dly = 2, cfg_len = 10, u_dly = 0, u_len = 0;
  bit stray = 1'b0;

  // Observed code statistics
  int n10, n01, n11, n_terr;
  logic [1:0] ord[$];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit a_v, input bit a_t, input bit r_v,
                            input bit busy, input bit rn);
    bit clr_a, clr_r, take_reg;
    clr_a = 0; clr_r = 0; take_reg = 0;
    m_code = 2'b00; m_terr = 0;
    if (!rn) begin
      m_apend = 0; m_atwo = 0; m_rpend = 0; m_last = 0; m_ovf = 0;
      m_active = 0; m_acked = 0; m_fin = 0; m_age = 0;
      m_sel = 0; m_sbusy = 0;
      m_words.delete();
      return;
    end
    if (!m_active) begin
      if (!busy && (m_apend || m_rpend)) begin
        take_reg = (m_apend && m_rpend) ? !m_last : m_rpend;
        m_last = take_reg;
        m_words.delete();
        if (take_reg) m_words.push_back(2'b11);
        else begin
          m_words.push_back(2'b10);
          if (m_atwo) m_words.push_back(2'b01);
        end
        m_code = m_words[0]; m_sel = 0;
        m_active = 1; m_age = 0; m_acked = 0; m_fin = 0;
      end
    end else if (m_fin) begin
      void'(m_words.pop_front());
      if (m_words.size() != 0) begin
        m_code = m_words[0]; m_sel = 1;
        m_age = 0; m_acked = 0; m_fin = 0;
      end else begin
        if (m_last) clr_r = 1; else clr_a = 1;
        m_sel = 0; m_active = 0;
      end
    end else if (m_age == 0) begin
      m_age = 1;
    end else if (!m_acked) begin
      if (busy) m_acked = 1;
      else if (m_age == ACK_TO) begin m_terr = 1; m_fin = 1; end
      else m_age++;
    end else if (!busy) begin
      m_fin = 1;
    end
    if (clr_a) m_apend = 0;
    if (clr_r) m_rpend = 0;
    if (a_v) begin
      if (m_apend) m_ovf = 1;
      else begin m_apend = 1; m_atwo = a_t; end
    end
    if (r_v) begin
      if (m_rpend) m_ovf = 1;
      else m_rpend = 1;
    end
    m_sbusy = m_active || m_apend || m_rpend;
  endtask

  // One clock: drive inputs, advance the model, compare after the edge
  task automatic step(input bit a_v, input bit a_t, input bit r_v, input bit rn);
    bit b;
    if (u_dly > 0) begin u_dly--; b = 0; end
    else if (u_len > 0) begin u_len--; b = 1; end
    else b = 0;
    b = b | stray;
    rst_n = rn;
    ifc.alu_res_vld  = a_v;
    ifc.alu_two_word = a_t;
    ifc.reg_rd_vld   = r_v;
    ifc.tx_busy      = b;
    model_step(a_v, a_t, r_v, b, rn);
    @(posedge clk);
    #1;
    chk("send_ctrl_sig", 8'(ifc.send_ctrl_sig), 8'(m_code));
    chk("alu_word_sel", 8'(ifc.alu_word_sel), 8'(m_sel));
    chk("sched_busy", 8'(ifc.sched_busy), 8'(m_sbusy));
    chk("tx_timeout_err", 8'(ifc.tx_timeout_err), 8'(m_terr));
    chk("req_ovf_err", 8'(ifc.req_ovf_err), 8'(m_ovf));
    case (ifc.send_ctrl_sig)
      2'b10: begin n10++; ord.push_back(2'b10); end
      2'b01: begin n01++; ord.push_back(2'b01); end
      2'b11: begin n11++; ord.push_back(2'b11); end
      default: ;
    endcase
    if (ifc.tx_timeout_err === 1'b1) n_terr++;
    if (m_code != 2'b00) begin u_dly = cfg_dly; u_len = cfg_len; end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1);
  endtask

  task automatic clr_counts();
    n10 = 0; n01 = 0; n11 = 0; n_terr = 0;
    ord.delete();
  endtask

  initial begin
    ifc.alu_res_vld = 0; ifc.alu_two_word = 0; ifc.reg_rd_vld = 0; ifc.tx_busy = 0;

    // Reset state
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("rst_code", 8'(ifc.send_ctrl_sig), 8'h00);
    chk("rst_sched_busy", 8'(ifc.sched_busy), 8'h00);

    // Single-word ALU result
    cfg_dly = 2; cfg_len = 10; clr_counts();
    step(1, 0, 0, 1);
    run(25);
    chk("single_n10", 8'(n10), 8'd1);
    chk("single_n01", 8'(n01), 8'd0);
    chk("single_n11", 8'(n11), 8'd0);

    // Two-word ALU result
    clr_counts();
    step(1, 1, 0, 1);
    run(40);
    chk("two_n10", 8'(n10), 8'd1);
    chk("two_n01", 8'(n01), 8'd1);
    chk("two_n11", 8'(n11), 8'd0);

    // Simultaneous requests after reset: register first, then ALU, twice
    step(0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      clr_counts();
      step(1, 0, 1, 1);
      run(40);
      chk("rr_count", 8'(ord.size()), 8'd2);
      if (ord.size() == 2) begin
        chk("rr_first", 8'(ord[0]), 8'h03);
        chk("rr_second", 8'(ord[1]), 8'h02);
      end
    end

    // No acknowledge at all: both words time out, sequencer returns idle
    cfg_len = 0; clr_counts();
    step(1, 1, 0, 1);
    run(60);
    chk("to_err_pulses", 8'(n_terr), 8'd2);
    chk("to_n01", 8'(n01), 8'd1);
    chk("to_idle", 8'(ifc.sched_busy), 8'h00);

    // Overflow: repeated register requests while the first is in flight
    cfg_dly = 1; cfg_len = 8; clr_counts();
    step(0, 0, 1, 1);
    run(3);
    step(0, 0, 1, 1);
    run(1);
    step(0, 0, 1, 1);
    run(20);
    chk("ovf_sticky", 8'(ifc.req_ovf_err), 8'h01);
    chk("ovf_n11", 8'(n11), 8'd1);

    // Reset during the busy phase of word 0 of a two-word result
    step(0, 0, 0, 0);
    clr_counts();
    step(1, 1, 0, 1);
    run(5);
    step(0, 0, 0, 0);
    chk("mid_rst_code", 8'(ifc.send_ctrl_sig), 8'h00);
    chk("mid_rst_busy", 8'(ifc.sched_busy), 8'h00);
    chk("mid_rst_ovf", 8'(ifc.req_ovf_err), 8'h00);
    clr_counts();
    run(30);
    chk("mid_rst_n01", 8'(n01), 8'd0);
    chk("mid_rst_n10", 8'(n10), 8'd0);

    // Randomized traffic against the model
    step(0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      cfg_dly = $urandom_range(0, 3);
      cfg_len = ($urandom % 5 == 0) ? 0 : int'($urandom_range(1, 6));
      stray   = ($urandom % 20 == 0);
      step(($urandom % 6) == 0, $urandom % 2, ($urandom % 6) == 0, ($urandom % 150) != 0);
    end
    stray = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tx_send_scheduler.md
Name: tx_send_scheduler

Overview:
- Sequencer for the system-controller transmit datapath.
- Accepts ALU-result and register-read completion events and arbitrates between them (round-robin).
- Drives the 2-bit send-control code into the transmit-data register stage one word at a time, then paces the next word on the UART TX busy handshake.
- Splits two-word ALU results into a first-word and a second-word transfer, with a timeout guard on the TX acknowledge.

Parameters:
- ACK_TIMEOUT, 16: cycles to wait for tx_busy to rise after a word is issued; 1 to 2^TO_WIDTH-1.
- TO_WIDTH, 5: width of the acknowledge timeout counter.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RST  in  1  synchronous active-low reset.
- alu_res_vld  in  1  one-cycle pulse; ALU result ready for transmit.
- alu_two_word  in  1  sampled with alu_res_vld; 1 = result needs two words.
- reg_rd_vld  in  1  one-cycle pulse; register-read data ready for transmit.
- tx_busy  in  1  UART TX busy, already synchronised to CLK.
- send_ctrl_sig  out  2  00 idle, 10 ALU word 0, 01 ALU word 1, 11 register word.
- alu_word_sel  out  1  ALU half select for the tx mux; 0 = low word, 1 = high word.
- sched_busy  out  1  high whenever state is not IDLE or any request is pending.
- tx_timeout_err  out  1  one-cycle pulse when an acknowledge timeout expires.
- req_ovf_err  out  1  sticky; set when a request arrives while the same type is still pending.

Behaviour:
- Clock and reset: single clock CLK. RST is synchronous and active-low, sampled only on the CLK posedge.
- Reset values: all outputs 0. State = IDLE. alu_pend, alu_two, reg_pend, last_grant, timer all cleared.
- Reset mid-transfer: the next edge forces IDLE and send_ctrl_sig = 00. Any in-flight word is abandoned.
- Request capture:
  - alu_res_vld sets alu_pend and latches alu_two <= alu_two_word.
  - reg_rd_vld sets reg_pend.
  - A request pulse while its own pend flag is already set sets req_ovf_err. The new pulse is dropped; alu_two keeps its old value.
  - A pulse on the same edge as that type's completion clear is captured; set wins over clear, no overflow.
- All outputs are registered.
- IDLE:
  - Grants only when tx_busy = 0 and at least one pend flag is set.
  - If both are pending, grant the type not in last_grant (last_grant: 0 = ALU, 1 = REG).
  - Grant ALU -> ISSUE with code 10 and alu_word_sel = 0. Grant REG -> ISSUE with code 11.
  - Update last_grant on every grant.
- ISSUE:
  - send_ctrl_sig holds the code for exactly one cycle, then returns to 00.
  - Next state WAIT_ACK; timer cleared.
  - The downstream stage registers the code, so tx_data_vld pulses one cycle after ISSUE.
- WAIT_ACK:
  - tx_busy = 1 -> WAIT_DONE.
  - Otherwise the timer increments. When timer == ACK_TIMEOUT-1 and tx_busy is still 0: pulse tx_timeout_err and treat the word as sent (go to NEXT).
- WAIT_DONE: stay while tx_busy = 1. tx_busy = 0 -> NEXT. No timeout here.
- NEXT (one cycle):
  - If the granted type is ALU, alu_two = 1 and word 0 was just sent: ISSUE with code 01, alu_word_sel = 1.
  - Otherwise clear the granted pend flag, set alu_word_sel = 0, go to IDLE.
- alu_word_sel is stable from ISSUE through NEXT of its word.
- Minimum spacing between two issued codes: 4 cycles (ISSUE, WAIT_ACK, WAIT_DONE, NEXT) with a 1-cycle busy.
- A single-word ALU result never produces code 01.
- tx_busy already high in IDLE blocks all grants; pend flags are retained.

Decomposition:
- Shared package (sys_ctrl_pkg):
  - State enum: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, NEXT.
  - Send codes: SEND_NONE = 2'b00, SEND_ALU_W0 = 2'b10, SEND_ALU_W1 = 2'b01, SEND_REG = 2'b11. These are shared with the transmit-data register stage.
- One sub-module, tx_ack_timer: clear/enable counter with an expire flag, parameterised by ACK_TIMEOUT and TO_WIDTH.
- Arbiter and FSM stay in the top module.

Test Plan:
- Single-word ALU: alu_res_vld with alu_two_word = 0; tx_busy high for 10 cycles starting 2 cycles after the code.
  -> exactly one 10 code, alu_word_sel = 0, sched_busy drops 1 cycle after tx_busy falls.
- Two-word ALU, same busy model.
  -> code 10 with alu_word_sel = 0, then code 01 with alu_word_sel = 1 issued 1 cycle after the first busy falls; never 11.
- alu_res_vld and reg_rd_vld on the same cycle after reset (last_grant = 0).
  -> code 11 first, then 10; a second simultaneous pair gives 11, 10 again.
- tx_busy held at 0, ACK_TIMEOUT = 16.
  -> tx_timeout_err pulses 16 cycles after ISSUE; a two-word request proceeds to code 01; the FSM returns to IDLE.
- Overflow: two reg_rd_vld pulses 2 cycles apart while the first is in WAIT_DONE.
  -> req_ovf_err = 1 (sticky), only one 11 code sent.
- RST = 0 for one edge during WAIT_DONE of word 0.
  -> next cycle all outputs 0, state IDLE, no code 01 ever issued, pend flags clear.
